// File: rtl/sd_card_dat_responder.sv
// SD card DAT0 line responder: receives write blocks, returns a CRC status token and busy, and
// transmits read blocks. Define SD_DAT_CRC_EN to generate and check the CRC16 on the data bits.
module sd_card_dat_responder #(
    parameter int unsigned BLOCK_WORDS    = 4,
    parameter int unsigned NAC_CYCLES     = 2,
    parameter int unsigned BUSY_CYCLES    = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        sd_clock,
    input  logic        reset,
    input  logic        cmd_write,
    input  logic        cmd_read,
    input  logic        abort,
    input  logic        dat_in,
    output logic        dat_out,
    output logic        dat_oe,
    output logic [31:0] rx_data,
    output logic        rx_valid,
    input  logic [31:0] tx_data,
    output logic        tx_req,
    output logic        block_done,
    output logic        crc_error,
    output logic        rx_timeout,
    output logic        busy
);

    localparam int unsigned BLOCK_BITS = BLOCK_WORDS * 32;
    localparam int unsigned BIT_CNT_W  = $clog2(BLOCK_BITS) + 1;
    localparam int unsigned CYC_MAX_A  = (TIMEOUT_CYCLES > BUSY_CYCLES) ? TIMEOUT_CYCLES : BUSY_CYCLES;
    localparam int unsigned CYC_MAX_B  = (NAC_CYCLES > 16) ? NAC_CYCLES : 16;
    localparam int unsigned CYC_MAX    = (CYC_MAX_A > CYC_MAX_B) ? CYC_MAX_A : CYC_MAX_B;
    localparam int unsigned CYC_CNT_W  = $clog2(CYC_MAX + 1);

    localparam logic [BIT_CNT_W-1:0] BIT_LAST      = BIT_CNT_W'(BLOCK_BITS - 1);
    localparam logic [BIT_CNT_W-1:0] BIT_LAST_WORD = BIT_CNT_W'(BLOCK_BITS - 32);

    typedef enum logic [3:0] {
        StIdle, StRxWaitStart, StRxData, StRxCrc, StRxEnd, StStatusGap, StCrcStatus,
        StBusy, StTxNac, StTxStart, StTxData, StTxCrc, StTxEnd
    } state_t;

    state_t                 state_q;
    logic [BIT_CNT_W-1:0]   bit_cnt_q;
    logic [CYC_CNT_W-1:0]   cyc_cnt_q;
    logic [30:0]            rx_shift_q;
    logic [30:0]            tx_shift_q;
    logic                   status_ok_q;
    logic [3:0]             token_q;

`ifdef SD_DAT_CRC_EN
    logic [15:0] crc_q;
    logic [15:0] rx_crc_q;
    logic [15:0] crc_rx_next;
    logic [15:0] crc_tx_next;

    // Serial CRC16-CCITT, x^16 + x^12 + x^5 + 1.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
        logic fb;
        fb = crc[15] ^ bit_in;
        return {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    assign crc_rx_next = crc16_step(crc_q, dat_in);
    assign crc_tx_next = crc16_step(crc_q, dat_out);
`endif

    assign busy = (state_q != StIdle);

    always_ff @(posedge sd_clock) begin
        if (!reset) begin
            state_q     <= StIdle;
            bit_cnt_q   <= '0;
            cyc_cnt_q   <= '0;
            rx_shift_q  <= '0;
            tx_shift_q  <= '0;
            status_ok_q <= 1'b0;
            token_q     <= '0;
            dat_out     <= 1'b1;
            dat_oe      <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_req      <= 1'b0;
            block_done  <= 1'b0;
            crc_error   <= 1'b0;
            rx_timeout  <= 1'b0;
`ifdef SD_DAT_CRC_EN
            crc_q       <= '0;
            rx_crc_q    <= '0;
`endif
        end else begin
            rx_valid   <= 1'b0;
            tx_req     <= 1'b0;
            block_done <= 1'b0;
            crc_error  <= 1'b0;
            rx_timeout <= 1'b0;
            if (abort) begin
                state_q <= StIdle;
                dat_oe  <= 1'b0;
                dat_out <= 1'b1;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        cyc_cnt_q <= '0;
                        if (cmd_write) begin
                            state_q <= StRxWaitStart;
                        end else if (cmd_read) begin
                            state_q <= StTxNac;
                            dat_oe  <= 1'b1;
                            dat_out <= 1'b1;
                        end
                    end
                    StRxWaitStart: begin
                        if (!dat_in) begin
                            state_q   <= StRxData;
                            bit_cnt_q <= '0;
`ifdef SD_DAT_CRC_EN
                            crc_q     <= '0;
`endif
                        end else if (cyc_cnt_q == CYC_CNT_W'(TIMEOUT_CYCLES - 1)) begin
                            rx_timeout <= 1'b1;
                            state_q    <= StIdle;
                        end else begin
                            cyc_cnt_q <= cyc_cnt_q + CYC_CNT_W'(1);
                        end
                    end
                    StRxData: begin
                        rx_shift_q <= {rx_shift_q[29:0], dat_in};
                        bit_cnt_q  <= bit_cnt_q + BIT_CNT_W'(1);
`ifdef SD_DAT_CRC_EN
                        crc_q      <= crc_rx_next;
`endif
                        if (bit_cnt_q[4:0] == 5'd31) begin
                            rx_data  <= {rx_shift_q, dat_in};
                            rx_valid <= 1'b1;
                        end
                        if (bit_cnt_q == BIT_LAST) begin
                            state_q   <= StRxCrc;
                            cyc_cnt_q <= '0;
                        end
                    end
                    StRxCrc: begin
`ifdef SD_DAT_CRC_EN
                        rx_crc_q <= {rx_crc_q[14:0], dat_in};
`endif
                        if (cyc_cnt_q == CYC_CNT_W'(15)) begin
                            state_q <= StRxEnd;
                        end else begin
                            cyc_cnt_q <= cyc_cnt_q + CYC_CNT_W'(1);
                        end
                    end
                    StRxEnd: begin
`ifdef SD_DAT_CRC_EN
                        status_ok_q <= dat_in && (rx_crc_q == crc_q);
`else
                        status_ok_q <= dat_in;
`endif
                        state_q   <= StStatusGap;
                        cyc_cnt_q <= '0;
                    end
                    StStatusGap: begin
                        if (cyc_cnt_q == CYC_CNT_W'(1)) begin
                            // First token bit is always 0; token_q holds the remaining four.
                            state_q   <= StCrcStatus;
                            dat_oe    <= 1'b1;
                            dat_out   <= 1'b0;
                            token_q   <= status_ok_q ? 4'b0101 : 4'b1011;
                            crc_error <= !status_ok_q;
                            cyc_cnt_q <= '0;
                        end else begin
                            cyc_cnt_q <= cyc_cnt_q + CYC_CNT_W'(1);
                        end
                    end
                    StCrcStatus: begin
                        if (cyc_cnt_q == CYC_CNT_W'(4)) begin
                            cyc_cnt_q <= '0;
                            if (status_ok_q) begin
                                state_q <= StBusy;
                                dat_out <= 1'b0;
                            end else begin
                                state_q <= StIdle;
                                dat_oe  <= 1'b0;
                                dat_out <= 1'b1;
                            end
                        end else begin
                            dat_out   <= token_q[3];
                            token_q   <= {token_q[2:0], 1'b0};
                            cyc_cnt_q <= cyc_cnt_q + CYC_CNT_W'(1);
                        end
                    end
                    StBusy: begin
                        if (cyc_cnt_q == CYC_CNT_W'(BUSY_CYCLES - 1)) begin
                            block_done <= 1'b1;
                            state_q    <= StIdle;
                            dat_oe     <= 1'b0;
                            dat_out    <= 1'b1;
                        end else begin
                            cyc_cnt_q <= cyc_cnt_q + CYC_CNT_W'(1);
                        end
                    end
                    StTxNac: begin
                        if (cyc_cnt_q == CYC_CNT_W'(NAC_CYCLES - 1)) begin
                            state_q <= StTxStart;
                            dat_out <= 1'b0;
                            tx_req  <= 1'b1;
`ifdef SD_DAT_CRC_EN
                            crc_q   <= '0;
`endif
                        end else begin
                            cyc_cnt_q <= cyc_cnt_q + CYC_CNT_W'(1);
                        end
                    end
                    StTxStart: begin
                        state_q    <= StTxData;
                        dat_out    <= tx_data[31];
                        tx_shift_q <= tx_data[30:0];
                        bit_cnt_q  <= '0;
                    end
                    StTxData: begin
                        bit_cnt_q <= bit_cnt_q + BIT_CNT_W'(1);
                        // Request the next word while the last bit of a non-final word is on the line.
                        tx_req    <= (bit_cnt_q[4:0] == 5'd30) && (bit_cnt_q < BIT_LAST_WORD);
`ifdef SD_DAT_CRC_EN
                        crc_q     <= crc_tx_next;
`endif
                        if (bit_cnt_q == BIT_LAST) begin
                            state_q   <= StTxCrc;
                            cyc_cnt_q <= '0;
`ifdef SD_DAT_CRC_EN
                            dat_out   <= crc_tx_next[15];
`else
                            dat_out   <= 1'b0;
`endif
                        end else if (bit_cnt_q[4:0] == 5'd31) begin
                            dat_out    <= tx_data[31];
                            tx_shift_q <= tx_data[30:0];
                        end else begin
                            dat_out    <= tx_shift_q[30];
                            tx_shift_q <= {tx_shift_q[29:0], 1'b0};
                        end
                    end
                    StTxCrc: begin
                        if (cyc_cnt_q == CYC_CNT_W'(15)) begin
                            state_q <= StTxEnd;
                            dat_out <= 1'b1;
                        end else begin
`ifdef SD_DAT_CRC_EN
                            dat_out <= crc_q[14];
                            crc_q   <= {crc_q[14:0], 1'b0};
`else
                            dat_out <= 1'b0;
`endif
                            cyc_cnt_q <= cyc_cnt_q + CYC_CNT_W'(1);
                        end
                    end
                    StTxEnd: begin
                        block_done <= 1'b1;
                        state_q    <= StIdle;
                        dat_oe     <= 1'b0;
                        dat_out    <= 1'b1;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sd_card_dat_responder.sv
// Self-checking bench for sd_card_dat_responder: write/read blocks, timeout, abort and reset
// scenarios compared against a bit-stream model with a long-division CRC reference.
module tb_sd_card_dat_responder;

    localparam int BW    = 4;
    localparam int NAC   = 2;
    localparam int BUSYC = 8;
    localparam int TMO   = 1024;
    localparam int NBITS = BW * 32;

    logic        sd_clock = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_write = 1'b0;
    logic        cmd_read = 1'b0;
    logic        abort = 1'b0;
    logic        dat_in = 1'b1;
    logic [31:0] tx_data = '0;
    logic        dat_out, dat_oe, rx_valid, tx_req, block_done, crc_error, rx_timeout, busy;
    logic [31:0] rx_data;

    int checks = 0;
    int errors = 0;
    logic [31:0] blk [BW];

    sd_card_dat_responder #(
        .BLOCK_WORDS(BW), .NAC_CYCLES(NAC), .BUSY_CYCLES(BUSYC), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .sd_clock(sd_clock), .reset(reset), .cmd_write(cmd_write), .cmd_read(cmd_read),
        .abort(abort), .dat_in(dat_in), .dat_out(dat_out), .dat_oe(dat_oe), .rx_data(rx_data),
        .rx_valid(rx_valid), .tx_data(tx_data), .tx_req(tx_req), .block_done(block_done),
        .crc_error(crc_error), .rx_timeout(rx_timeout), .busy(busy)
    );

    always #5 sd_clock = ~sd_clock;

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish, required finish before 3ms");
        $fatal(1, "watchdog");
    end

    // CRC as the remainder of (message * x^16) divided by the generator, by long division.
    function automatic logic [15:0] ref_crc();
        logic m [NBITS+16];
        logic [16:0] poly;
        logic [15:0] r;
        poly = 17'h11021;
        for (int i = 0; i < NBITS + 16; i++) m[i] = (i < NBITS) ? blk[i/32][31-(i%32)] : 1'b0;
        for (int i = 0; i < NBITS; i++)
            if (m[i]) for (int j = 0; j <= 16; j++) m[i+j] = m[i+j] ^ poly[16-j];
        for (int i = 0; i < 16; i++) r[15-i] = m[NBITS+i];
        return r;
    endfunction

    function automatic logic [15:0] line_crc();
`ifdef SD_DAT_CRC_EN
        return ref_crc();
`else
        return 16'h0000;
`endif
    endfunction

    function automatic bit crc_checked();
`ifdef SD_DAT_CRC_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge sd_clock);
        checks++; if (dat_oe !== 1'b0) begin errors++; $display("FAIL reset_oe got %b want 0", dat_oe); end
        checks++; if (dat_out !== 1'b1) begin errors++; $display("FAIL reset_out got %b want 1", dat_out); end
        checks++; if (rx_data !== 32'h0) begin errors++; $display("FAIL reset_rx_data got %h want 0", rx_data); end
        checks++;
        if ({rx_valid, tx_req, block_done, crc_error, rx_timeout, busy} !== 6'b0) begin
            errors++;
            $display("FAIL reset_pulses got %b want 000000",
                     {rx_valid, tx_req, block_done, crc_error, rx_timeout, busy});
        end
        reset = 1'b1;
        @(negedge sd_clock);
    endtask

    // Host sends one block (blk) after 'gap' idle cycles; checks words, status token and busy.
    task automatic do_write(input string name, input int gap, input bit flip_crc0, input bit end_bit);
        logic h [$];
        logic [15:0] crc;
        logic [4:0] tok;
        bit ok, exp_v;
        int ds, nv, d, last;
        crc = ref_crc();
        if (flip_crc0) crc[0] = ~crc[0];
        for (int i = 0; i < gap; i++) h.push_back(1'b1);
        h.push_back(1'b0);
        ds = h.size();
        for (int i = 0; i < NBITS; i++) h.push_back(blk[i/32][31-(i%32)]);
        for (int i = 15; i >= 0; i--) h.push_back(crc[i]);
        h.push_back(end_bit);
        ok = end_bit && !(flip_crc0 && crc_checked());
        tok = ok ? 5'b00101 : 5'b01011;
        nv = 0;
        @(negedge sd_clock);
        cmd_write = 1'b1;
        dat_in = 1'b1;
        for (int j = 0; j < h.size(); j++) begin
            @(negedge sd_clock);
            cmd_write = 1'b0;
            if (j > 0) begin
                d = j - 1 - ds;
                exp_v = (d >= 0) && (d < NBITS) && (d % 32 == 31);
                checks++;
                if (rx_valid !== exp_v) begin
                    errors++; $display("FAIL %s rx_valid at host bit %0d got %b want %b", name, j-1, rx_valid, exp_v);
                end
                if (rx_valid === 1'b1 && exp_v) begin
                    checks++;
                    if (rx_data !== blk[d/32]) begin
                        errors++; $display("FAIL %s rx_data word %0d got %h want %h", name, d/32, rx_data, blk[d/32]);
                    end
                    nv++;
                end
                checks++;
                if (dat_oe !== 1'b0) begin errors++; $display("FAIL %s rx dat_oe got %b want 0", name, dat_oe); end
            end
            dat_in = h[j];
        end
        last = ok ? 2 + 5 + BUSYC : 2 + 5;
        for (int i = 0; i <= last; i++) begin
            @(negedge sd_clock);
            dat_in = 1'b1;
            if (i < 2) begin
                checks++; if (dat_oe !== 1'b0) begin errors++; $display("FAIL %s gap dat_oe got %b want 0", name, dat_oe); end
            end else if (i < 7) begin
                checks++;
                if (dat_oe !== 1'b1 || dat_out !== tok[4-(i-2)]) begin
                    errors++; $display("FAIL %s token bit %0d got oe=%b out=%b want oe=1 out=%b", name, i-2, dat_oe, dat_out, tok[4-(i-2)]);
                end
            end else if (i < last) begin
                checks++;
                if (dat_oe !== 1'b1 || dat_out !== 1'b0) begin
                    errors++; $display("FAIL %s busy cycle %0d got oe=%b out=%b want oe=1 out=0", name, i-7, dat_oe, dat_out);
                end
            end else begin
                checks++;
                if (dat_oe !== 1'b0 || busy !== 1'b0 || block_done !== ok) begin
                    errors++; $display("FAIL %s finish got oe=%b busy=%b done=%b want oe=0 busy=0 done=%b", name, dat_oe, busy, block_done, ok);
                end
            end
            if (i < last) begin
                checks++;
                if (block_done !== 1'b0) begin errors++; $display("FAIL %s early block_done got 1 want 0", name); end
            end
            checks++;
            if (crc_error !== (i == 2 && !ok)) begin
                errors++; $display("FAIL %s crc_error at %0d got %b want %b", name, i, crc_error, (i == 2 && !ok));
            end
        end
        checks++;
        if (nv != BW) begin errors++; $display("FAIL %s rx_valid count got %0d want %0d", name, nv, BW); end
    endtask

    // Card sends one block (blk); checks the whole DAT0 stream, tx_req timing and completion.
    task automatic do_read(input string name);
        logic s [$];
        logic [15:0] crc;
        int nreq, d;
        bit exp_req;
        crc = line_crc();
        for (int i = 0; i < NAC; i++) s.push_back(1'b1);
        s.push_back(1'b0);
        for (int i = 0; i < NBITS; i++) s.push_back(blk[i/32][31-(i%32)]);
        for (int i = 15; i >= 0; i--) s.push_back(crc[i]);
        s.push_back(1'b1);
        nreq = 0;
        @(negedge sd_clock);
        cmd_read = 1'b1;
        tx_data = blk[0];
        for (int k = 1; k <= s.size() + 1; k++) begin
            @(negedge sd_clock);
            cmd_read = 1'b0;
            tx_data = blk[nreq < BW ? nreq : BW-1];
            if (k <= s.size()) begin
                d = k - 1 - NAC - 1;
                exp_req = (k - 1 == NAC) || (d >= 0 && d < NBITS - 32 && d % 32 == 31);
                checks++;
                if (dat_oe !== 1'b1 || dat_out !== s[k-1]) begin
                    errors++; $display("FAIL %s line bit %0d got oe=%b out=%b want oe=1 out=%b", name, k-1, dat_oe, dat_out, s[k-1]);
                end
                checks++;
                if (tx_req !== exp_req) begin
                    errors++; $display("FAIL %s tx_req at %0d got %b want %b", name, k-1, tx_req, exp_req);
                end
                checks++;
                if (block_done !== 1'b0) begin errors++; $display("FAIL %s early block_done got 1 want 0", name); end
            end else begin
                checks++;
                if (dat_oe !== 1'b0 || block_done !== 1'b1 || busy !== 1'b0) begin
                    errors++; $display("FAIL %s finish got oe=%b done=%b busy=%b want oe=0 done=1 busy=0", name, dat_oe, block_done, busy);
                end
            end
            if (tx_req === 1'b1) nreq++;
        end
        checks++;
        if (nreq != BW) begin errors++; $display("FAIL %s tx_req count got %0d want %0d", name, nreq, BW); end
    endtask

    task automatic test_good_write();
        blk[0] = 32'hDEADBEEF; blk[1] = 32'h01234567; blk[2] = 32'h89ABCDEF; blk[3] = 32'h0F0F0F0F;
        do_write("good_write", 0, 1'b0, 1'b1);
    endtask

    task automatic test_corrupt_write();
        do_write("corrupt_write", 2, 1'b1, 1'b1);
    endtask

    task automatic test_bad_end_bit();
        do_write("bad_end_bit", 1, 1'b0, 1'b0);
    endtask

    task automatic test_random_writes();
        for (int n = 0; n < 4; n++) begin
            for (int w = 0; w < BW; w++) blk[w] = $urandom();
            do_write("random_write", int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 3) != 0));
        end
    endtask

    task automatic test_read();
        blk[0] = 32'hA5A5A5A5; blk[1] = 32'h0; blk[2] = 32'hFFFFFFFF; blk[3] = 32'h5A5A5A5A;
        do_read("read_fixed");
        for (int n = 0; n < 3; n++) begin
            for (int w = 0; w < BW; w++) blk[w] = $urandom();
            do_read("read_random");
        end
    endtask

    task automatic test_timeout();
        int seen;
        seen = -1;
        @(negedge sd_clock);
        cmd_write = 1'b1;
        dat_in = 1'b1;
        for (int k = 1; k <= TMO + 20; k++) begin
            @(negedge sd_clock);
            cmd_write = 1'b0;
            if (rx_timeout === 1'b1 && seen < 0) seen = k;
            if (k == TMO) begin
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL timeout_busy_wait got %b want 1", busy); end
            end
            if (k == TMO + 2) begin
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout_busy_after got %b want 0", busy); end
            end
        end
        checks++;
        if (seen != TMO + 1) begin errors++; $display("FAIL timeout_cycle got %0d want %0d", seen, TMO + 1); end
    endtask

    task automatic test_abort();
        int nv, nd;
        nv = 0; nd = 0;
        @(negedge sd_clock);
        cmd_write = 1'b1;
        for (int j = 0; j <= 41; j++) begin
            @(negedge sd_clock);
            cmd_write = 1'b0;
            if (rx_valid === 1'b1) nv++;
            dat_in = (j == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            if (j == 41) abort = 1'b1;
        end
        @(negedge sd_clock);
        abort = 1'b0;
        dat_in = 1'b1;
        if (rx_valid === 1'b1) nv++;
        checks++;
        if (busy !== 1'b0 || dat_oe !== 1'b0) begin
            errors++; $display("FAIL abort_idle got busy=%b oe=%b want busy=0 oe=0", busy, dat_oe);
        end
        for (int k = 0; k < 200; k++) begin
            @(negedge sd_clock);
            if (rx_valid === 1'b1) nv++;
            if (block_done === 1'b1) nd++;
        end
        checks++; if (nv != 1) begin errors++; $display("FAIL abort_rx_valid_count got %0d want 1", nv); end
        checks++; if (nd != 0) begin errors++; $display("FAIL abort_block_done got %0d want 0", nd); end
    endtask

    task automatic test_simultaneous();
        int nr;
        nr = 0;
        @(negedge sd_clock);
        cmd_write = 1'b1;
        cmd_read = 1'b1;
        dat_in = 1'b1;
        @(negedge sd_clock);
        cmd_write = 1'b0;
        cmd_read = 1'b0;
        checks++;
        if (busy !== 1'b1 || dat_oe !== 1'b0) begin
            errors++; $display("FAIL simul_write_path got busy=%b oe=%b want busy=1 oe=0", busy, dat_oe);
        end
        for (int k = 0; k < 6; k++) begin
            @(negedge sd_clock);
            if (tx_req === 1'b1 || dat_oe === 1'b1) nr++;
        end
        checks++; if (nr != 0) begin errors++; $display("FAIL simul_no_read got %0d read cycles want 0", nr); end
        abort = 1'b1;
        @(negedge sd_clock);
        abort = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL simul_abort busy got %b want 0", busy); end
    endtask

    task automatic test_reset_mid_tx();
        int nd;
        nd = 0;
        for (int w = 0; w < BW; w++) blk[w] = $urandom();
        @(negedge sd_clock);
        cmd_read = 1'b1;
        tx_data = blk[0];
        for (int k = 0; k < NAC + 20; k++) begin
            @(negedge sd_clock);
            cmd_read = 1'b0;
        end
        checks++; if (dat_oe !== 1'b1) begin errors++; $display("FAIL rst_tx_active oe got %b want 1", dat_oe); end
        reset = 1'b0;
        @(negedge sd_clock);
        checks++;
        if (dat_oe !== 1'b0 || dat_out !== 1'b1 || rx_data !== 32'h0 || busy !== 1'b0 ||
            {rx_valid, tx_req, block_done, crc_error, rx_timeout} !== 5'b0) begin
            errors++;
            $display("FAIL rst_mid_tx got oe=%b out=%b rx_data=%h busy=%b pulses=%b want oe=0 out=1 rx_data=0 busy=0 pulses=00000",
                     dat_oe, dat_out, rx_data, busy, {rx_valid, tx_req, block_done, crc_error, rx_timeout});
        end
        reset = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge sd_clock);
            if (block_done === 1'b1 || crc_error === 1'b1 || dat_oe === 1'b1) nd++;
        end
        checks++; if (nd != 0) begin errors++; $display("FAIL rst_mid_tx_after got %0d event cycles want 0", nd); end
    endtask

    initial begin
        test_reset();
        test_good_write();
        test_corrupt_write();
        test_bad_end_bit();
        test_random_writes();
        test_read();
        test_timeout();
        test_abort();
        test_simultaneous();
        test_reset_mid_tx();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sd_card_dat_responder.md
SD_CARD_DAT_RESPONDER -- requirements
Module: sd_card_dat_responder

Interface
REQ-001 Parameter BLOCK_WORDS, default 4: 32-bit words per data block.
REQ-002 Parameter NAC_CYCLES, default 2: idle cycles between cmd_read and the read start bit.
REQ-003 Parameter BUSY_CYCLES, default 8: cycles DAT is held low after a write CRC status token.
REQ-004 Parameter TIMEOUT_CYCLES, default 1024: maximum wait for a write start bit.
REQ-005 sd_clock  in  1  sole clock; all logic on the rising edge.
REQ-006 reset  in  1  synchronous, active-low reset.
REQ-007 cmd_write  in  1  one-cycle pulse; arms reception of one write block.
REQ-008 cmd_read  in  1  one-cycle pulse; starts transmission of one read block.
REQ-009 abort  in  1  level; forces return to IDLE.
REQ-010 dat_in  in  1  DAT0 from the pad, sampled every cycle.
REQ-011 dat_out  out  1  DAT0 value driven toward the host.
REQ-012 dat_oe  out  1  pad drive enable; 1 = card drives DAT0.
REQ-013 rx_data  out  32  last received write word.
REQ-014 rx_valid  out  1  one-cycle pulse; rx_data is valid.
REQ-015 tx_data  in  32  next read word; must be valid while tx_req=1 (first-word fall-through).
REQ-016 tx_req  out  1  one-cycle pulse; tx_data is consumed this cycle.
REQ-017 block_done  out  1  one-cycle pulse on block completion.
REQ-018 crc_error  out  1  one-cycle pulse on a bad write CRC or a bad end bit.
REQ-019 rx_timeout  out  1  one-cycle pulse when no start bit arrives.
REQ-020 busy  out  1  high in any state other than IDLE.

Function
REQ-021 States: IDLE, RX_WAIT_START, RX_DATA, RX_CRC, RX_END, STATUS_GAP, CRC_STATUS, BUSY, TX_NAC, TX_START, TX_DATA, TX_CRC, TX_END.
REQ-022 Transitions from IDLE: cmd_write -> RX_WAIT_START; cmd_read -> TX_NAC; if both are set in the same cycle, cmd_write wins; cmd_* pulses outside IDLE are ignored.
REQ-023 RX_WAIT_START: dat_in=0 -> RX_DATA next cycle; after TIMEOUT_CYCLES cycles with dat_in=1 -> pulse rx_timeout, go to IDLE.
REQ-024 RX_DATA bit handling: shift in BLOCK_WORDS*32 bits, MSB first, one bit per cycle.
REQ-025 RX_DATA word output: rx_valid pulses in the cycle after each 32nd bit is sampled; after the last word -> RX_CRC.
REQ-026 RX_CRC: shift 16 CRC bits MSB first -> RX_END.
REQ-027 RX_END: sample the end bit -> STATUS_GAP; the status is positive only if the CRC matched and the end bit is 1.
REQ-028 STATUS_GAP lasts 2 cycles with dat_oe=0.
REQ-029 CRC_STATUS drives 5 bits with dat_oe=1: positive 0,0,1,0,1; negative 0,1,0,1,1.
REQ-030 crc_error pulses in the first CRC_STATUS cycle when the status is negative.
REQ-031 BUSY, positive status: dat_oe=1, dat_out=0 for BUSY_CYCLES cycles, then pulse block_done, go to IDLE.
REQ-032 BUSY, negative status: BUSY is skipped; go directly to IDLE without a block_done pulse.
REQ-033 TX_NAC: dat_oe=1, dat_out=1 for NAC_CYCLES cycles -> TX_START.
REQ-034 TX_START: dat_out=0 for 1 cycle; tx_req pulses in this cycle to load word 0.
REQ-035 TX_DATA: drive BLOCK_WORDS*32 bits MSB first; tx_req pulses in the cycle the last bit of each non-final word is driven, loading the following word.
REQ-036 TX_CRC drives 16 CRC bits, then TX_END drives 1 for 1 cycle.
REQ-037 TX completion: after TX_END, pulse block_done, set dat_oe=0, go to IDLE.
REQ-038 CRC16 rules: polynomial x^16+x^12+x^5+1; register initialised to 0 at each start bit; covers data bits only.
REQ-039 Counter widths: bit counter is log2(BLOCK_WORDS*32)+1 bits; cycle counters are wide enough for their parameter; no counter wraps within a block.
REQ-040 Abort: abort=1 in any state -> IDLE on the next edge with dat_oe=0; no block_done pulse; any partial word is discarded without rx_valid.
REQ-041 Output default: dat_oe=0 in IDLE, RX_WAIT_START, RX_DATA, RX_CRC, RX_END and STATUS_GAP.

Reset
REQ-042 While reset=0 at an edge: state=IDLE, dat_oe=0, dat_out=1, rx_data=0, all pulse outputs=0, busy=0, all counters and the CRC register cleared.
REQ-043 Reset mid-block: the block is abandoned and no completion or error pulse is produced.

Configuration
REQ-044 Macro SD_DAT_CRC_EN: when defined, the CRC16 is generated on read and checked on write per REQ-038.
REQ-045 Without SD_DAT_CRC_EN: the CRC register is omitted; TX_CRC drives 16 zeros; received CRC bits are ignored and the status is negative only on a bad end bit.

Verification
REQ-046 Good write: cmd_write, host sends 0 + 0xDEADBEEF,0x01234567,0x89ABCDEF,0x0F0F0F0F + correct CRC + 1 -> four rx_valid pulses with those words; status bits 0,0,1,0,1; 8 busy-low cycles; block_done.
REQ-047 Corrupt write: same block with CRC bit 0 flipped -> crc_error pulse; status bits 0,1,0,1,1; no BUSY; IDLE.
REQ-048 Read: cmd_read with tx_data sequence 0xA5A5A5A5,0,0xFFFFFFFF,0x5A5A5A5A -> start bit 3 cycles after cmd_read (2 NAC cycles); exactly 4 tx_req pulses; 128 data bits MSB first; CRC matching a reference model; end bit 1; block_done.
REQ-049 Timeout: cmd_write with dat_in held at 1 -> rx_timeout pulse after 1024 cycles; busy=0 on the next cycle.
REQ-050 Abort at bit 40 of RX_DATA -> IDLE next cycle; exactly one rx_valid pulse in total; no block_done.
REQ-051 Simultaneous events and reset: cmd_write and cmd_read in the same cycle -> write path taken; reset=0 during TX_DATA -> dat_oe=0 and all outputs at reset values on the next edge.
